// File: rtl/sel_mux_reg.sv
// sel_mux_reg: N-to-1 lane mux with a combinational output and a valid-qualified registered copy.
// Latency: muxout/sel_err 0 cycles; muxout_q/sel_err_q/out_valid 1 cycle after the sampling edge.
// Backpressure: none; every in_valid beat is captured on the next rising edge.
module sel_mux_reg #(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
    input  logic [SEL_WIDTH-1:0]       select,
    input  logic                       in_valid,
    output logic [BIT_WIDTH-1:0]       muxout,
    output logic                       sel_err,
    output logic [BIT_WIDTH-1:0]       muxout_q,
    output logic                       out_valid,
    output logic                       sel_err_q
);

    logic [BIT_WIDTH-1:0] muxout_d;
    logic                 sel_err_d;
    logic                 out_valid_d;
    logic                 out_valid_q;

    // An index that matches no lane falls through to zero data with the error flag raised.
    always_comb begin
        muxout  = '0;
        sel_err = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (select == SEL_WIDTH'(i)) begin
                muxout  = dataIn[i*BIT_WIDTH +: BIT_WIDTH];
                sel_err = 1'b0;
            end
        end
    end

    always_comb begin
        out_valid_d = in_valid;
        muxout_d    = muxout_q;
        sel_err_d   = sel_err_q;
        if (in_valid) begin
            muxout_d  = muxout;
            sel_err_d = sel_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            muxout_q    <= '0;
            sel_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            muxout_q    <= muxout_d;
            sel_err_q   <= sel_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sel_mux_reg.sv
// Bench for sel_mux_reg: default, short (DEPTH=3) and wide (8x8) instances checked against
// directed expectations and a shift-and-mask lane model under random stimulus.
module tb_sel_mux_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance: 4 lanes of 4 bits
    logic [15:0] a_din;
    logic [1:0]  a_sel;
    logic        a_vld;
    logic [3:0]  a_mux, a_mux_q;
    logic        a_err, a_ovld, a_err_q;

    // Short instance: 3 lanes of 4 bits, select 3 is out of range
    logic [11:0] b_din;
    logic [1:0]  b_sel;
    logic        b_vld;
    logic [3:0]  b_mux, b_mux_q;
    logic        b_err, b_ovld, b_err_q;

    // Wide instance: 8 lanes of 8 bits
    logic [63:0] c_din;
    logic [2:0]  c_sel;
    logic        c_vld;
    logic [7:0]  c_mux, c_mux_q;
    logic        c_err, c_ovld, c_err_q;

    sel_mux_reg #(.BIT_WIDTH(4), .DEPTH(4), .SEL_WIDTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .dataIn(a_din), .select(a_sel), .in_valid(a_vld),
        .muxout(a_mux), .sel_err(a_err), .muxout_q(a_mux_q), .out_valid(a_ovld), .sel_err_q(a_err_q)
    );
    sel_mux_reg #(.BIT_WIDTH(4), .DEPTH(3), .SEL_WIDTH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .dataIn(b_din), .select(b_sel), .in_valid(b_vld),
        .muxout(b_mux), .sel_err(b_err), .muxout_q(b_mux_q), .out_valid(b_ovld), .sel_err_q(b_err_q)
    );
    sel_mux_reg #(.BIT_WIDTH(8), .DEPTH(8), .SEL_WIDTH(3)) u_c (
        .clk(clk), .rst_n(rst_n), .dataIn(c_din), .select(c_sel), .in_valid(c_vld),
        .muxout(c_mux), .sel_err(c_err), .muxout_q(c_mux_q), .out_valid(c_ovld), .sel_err_q(c_err_q)
    );

    // Lane model: shift the packed bus right by whole lanes and mask one lane off.
    function automatic logic [63:0] ref_lane(input logic [63:0] d, input int w, input int s, input int depth);
        if (s >= depth) return 64'd0;
        return (d >> (w * s)) & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a_din = '0; a_sel = '0; a_vld = 1'b0;
        b_din = '0; b_sel = '0; b_vld = 1'b0;
        c_din = '0; c_sel = '0; c_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_mux_q, a_ovld, a_err_q} !== 6'd0) begin
            n_fail++; $display("FAIL reset_a: got q=%h vld=%b err=%b, want all 0", a_mux_q, a_ovld, a_err_q);
        end
        n_checks++;
        if ({b_mux_q, b_ovld, b_err_q} !== 6'd0) begin
            n_fail++; $display("FAIL reset_b: got q=%h vld=%b err=%b, want all 0", b_mux_q, b_ovld, b_err_q);
        end
        n_checks++;
        if ({c_mux_q, c_ovld, c_err_q} !== 10'd0) begin
            n_fail++; $display("FAIL reset_c: got q=%h vld=%b err=%b, want all 0", c_mux_q, c_ovld, c_err_q);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] exp_tab [4];
        exp_tab = '{4'hB, 4'h1, 4'h0, 4'h0};
        a_din = 16'h001B;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s); a_vld = 1'b1;
            #1;
            n_checks++;
            if (a_mux !== exp_tab[s] || a_err !== 1'b0) begin
                n_fail++; $display("FAIL sweep_comb sel=%0d: got mux=%h err=%b, want mux=%h err=0", s, a_mux, a_err, exp_tab[s]);
            end
            tick();
            n_checks++;
            if (a_mux_q !== exp_tab[s] || a_ovld !== 1'b1 || a_err_q !== 1'b0) begin
                n_fail++; $display("FAIL sweep_reg sel=%0d: got q=%h vld=%b err=%b, want q=%h vld=1 err=0",
                                   s, a_mux_q, a_ovld, a_err_q, exp_tab[s]);
            end
        end
        a_vld = 1'b0;
    endtask

    task automatic test_distinct();
        logic [3:0] exp_tab [4];
        exp_tab = '{4'h3, 4'hC, 4'h5, 4'hA};
        a_din = 16'hA5C3;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s); a_vld = 1'b1;
            #1;
            n_checks++;
            if (a_mux !== exp_tab[s]) begin
                n_fail++; $display("FAIL distinct sel=%0d: got %h, want %h", s, a_mux, exp_tab[s]);
            end
            tick();
        end
        a_vld = 1'b0;
    endtask

    task automatic test_out_of_range();
        b_din = 12'hFFF; b_sel = 2'd2; b_vld = 1'b1;
        tick();
        n_checks++;
        if (b_mux_q !== 4'hF || b_err_q !== 1'b0) begin
            n_fail++; $display("FAIL oor_inrange: got q=%h err=%b, want q=f err=0", b_mux_q, b_err_q);
        end
        b_sel = 2'd3;
        #1;
        n_checks++;
        if (b_mux !== 4'h0 || b_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_comb: got mux=%h err=%b, want mux=0 err=1", b_mux, b_err);
        end
        tick();
        n_checks++;
        if (b_mux_q !== 4'h0 || b_err_q !== 1'b1 || b_ovld !== 1'b1) begin
            n_fail++; $display("FAIL oor_reg: got q=%h err=%b vld=%b, want q=0 err=1 vld=1", b_mux_q, b_err_q, b_ovld);
        end
        b_vld = 1'b0;
    endtask

    task automatic test_hold();
        a_din = 16'h001B; a_sel = 2'd1; a_vld = 1'b1;
        tick();
        n_checks++;
        if (a_mux_q !== 4'h1 || a_ovld !== 1'b1) begin
            n_fail++; $display("FAIL hold_capture: got q=%h vld=%b, want q=1 vld=1", a_mux_q, a_ovld);
        end
        a_vld = 1'b0; a_sel = 2'd3; a_din = 16'h9FFF;
        #1;
        n_checks++;
        if (a_mux !== 4'h9) begin
            n_fail++; $display("FAIL hold_comb: got %h, want 9", a_mux);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (a_mux_q !== 4'h1 || a_ovld !== 1'b0 || a_err_q !== 1'b0) begin
                n_fail++; $display("FAIL hold_reg cycle %0d: got q=%h vld=%b err=%b, want q=1 vld=0 err=0",
                                   k, a_mux_q, a_ovld, a_err_q);
            end
            a_sel = 2'd0; a_din = 16'h0000;
        end
    endtask

    task automatic test_async_reset();
        a_din = 16'h001B; a_sel = 2'd0; a_vld = 1'b1;
        tick();
        n_checks++;
        if (a_mux_q !== 4'hB || a_ovld !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got q=%h vld=%b, want q=b vld=1", a_mux_q, a_ovld);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_mux_q, a_ovld, a_err_q} !== 6'd0) begin
            n_fail++; $display("FAIL areset_async: got q=%h vld=%b err=%b, want all 0", a_mux_q, a_ovld, a_err_q);
        end
        rst_n = 1'b1;
        #4;
        n_checks++;
        if ({a_mux_q, a_ovld} !== 5'd0) begin
            n_fail++; $display("FAIL areset_release: got q=%h vld=%b, want 0 before edge", a_mux_q, a_ovld);
        end
        tick();
        n_checks++;
        if (a_mux_q !== 4'hB || a_ovld !== 1'b1) begin
            n_fail++; $display("FAIL areset_resume: got q=%h vld=%b, want q=b vld=1", a_mux_q, a_ovld);
        end
        a_vld = 1'b0;
    endtask

    task automatic test_wide();
        for (int i = 0; i < 8; i++) c_din[i*8 +: 8] = 8'h10 + 8'(i);
        for (int s = 0; s < 8; s++) begin
            c_sel = 3'(s); c_vld = 1'b1;
            #1;
            n_checks++;
            if (c_mux !== 8'h10 + 8'(s) || c_err !== 1'b0) begin
                n_fail++; $display("FAIL wide_comb sel=%0d: got mux=%h err=%b, want %h", s, c_mux, c_err, 8'h10 + 8'(s));
            end
            tick();
            n_checks++;
            if (c_mux_q !== 8'h10 + 8'(s) || c_ovld !== 1'b1) begin
                n_fail++; $display("FAIL wide_reg sel=%0d: got q=%h vld=%b, want %h", s, c_mux_q, c_ovld, 8'h10 + 8'(s));
            end
        end
        c_vld = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] ea_q, eb_q;
        logic [7:0] ec_q;
        logic       ea_e, eb_e, ec_e;
        logic [63:0] ra, rb, rc;
        ea_q = '0; eb_q = '0; ec_q = '0; ea_e = 1'b0; eb_e = 1'b0; ec_e = 1'b0;
        for (int it = 0; it < 300; it++) begin
            a_din = 16'($urandom); a_sel = 2'($urandom_range(0, 3));
            b_din = 12'($urandom); b_sel = 2'($urandom_range(0, 3));
            c_din = {$urandom(), $urandom()}; c_sel = 3'($urandom_range(0, 7));
            a_vld = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            b_vld = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            c_vld = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ra = ref_lane(64'(a_din), 4, int'(a_sel), 4);
            rb = ref_lane(64'(b_din), 4, int'(b_sel), 3);
            rc = ref_lane(c_din, 8, int'(c_sel), 8);
            #1;
            n_checks++;
            if (a_mux !== 4'(ra) || a_err !== 1'b0 || b_mux !== 4'(rb) || b_err !== (int'(b_sel) >= 3)
                || c_mux !== 8'(rc) || c_err !== 1'b0) begin
                n_fail++; $display("FAIL rand_comb it=%0d: got a=%h/%b b=%h/%b c=%h/%b, want a=%h b=%h/%b c=%h",
                                   it, a_mux, a_err, b_mux, b_err, c_mux, c_err, 4'(ra), 4'(rb), int'(b_sel) >= 3, 8'(rc));
            end
            if (a_vld) begin ea_q = 4'(ra); ea_e = 1'b0; end
            if (b_vld) begin eb_q = 4'(rb); eb_e = (int'(b_sel) >= 3); end
            if (c_vld) begin ec_q = 8'(rc); ec_e = 1'b0; end
            tick();
            n_checks++;
            if (a_mux_q !== ea_q || a_err_q !== ea_e || a_ovld !== a_vld
                || b_mux_q !== eb_q || b_err_q !== eb_e || b_ovld !== b_vld
                || c_mux_q !== ec_q || c_err_q !== ec_e || c_ovld !== c_vld) begin
                n_fail++; $display("FAIL rand_reg it=%0d: got a=%h/%b/%b b=%h/%b/%b c=%h/%b/%b, want a=%h/%b/%b b=%h/%b/%b c=%h/%b/%b",
                                   it, a_mux_q, a_err_q, a_ovld, b_mux_q, b_err_q, b_ovld, c_mux_q, c_err_q, c_ovld,
                                   ea_q, ea_e, a_vld, eb_q, eb_e, b_vld, ec_q, ec_e, c_vld);
            end
        end
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_distinct();
        test_out_of_range();
        test_hold();
        test_async_reset();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
